// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, RV64I opcodes and the decoded request
// bundle passed from decode to the pipeline register.
package alu_pkg;

  localparam int XLEN_C = 64;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_ADDW = 4'd10,
    ALU_SUBW = 4'd11,
    ALU_SLLW = 4'd12,
    ALU_SRLW = 4'd13,
    ALU_SRAW = 4'd14
  } alu_op_t;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN_C-1:0] a;
    logic [XLEN_C-1:0] b;
    alu_op_t           aluc;
    logic [4:0]        rd;
    logic              wen;
    logic              illegal;
  } alu_req_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV64I integer-ALU decoder: instruction, PC and register
// operands in, ALU op code plus operands out.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [XLEN_C-1:0] pc,
  input  logic [XLEN_C-1:0] rs1,
  input  logic [XLEN_C-1:0] rs2,
  output alu_req_t          req
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [XLEN_C-1:0] imm_i;
  logic [XLEN_C-1:0] imm_u;
  logic [XLEN_C-1:0] shamt6;
  logic [XLEN_C-1:0] shamt5;

  logic              legal;
  alu_op_t           op;
  logic [XLEN_C-1:0] opa;
  logic [XLEN_C-1:0] opb;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_u  = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign shamt6 = {58'b0, instr[25:20]};
  assign shamt5 = {59'b0, instr[24:20]};

  always_comb begin
    legal = 1'b1;
    op    = ALU_ADD;
    opa   = rs1;
    opb   = rs2;
    case (opcode)
      OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: op = ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OP_IMM: begin
        opb = imm_i;
        case (funct3)
          3'b000: op = ALU_ADD;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b110: op = ALU_OR;
          3'b111: op = ALU_AND;
          3'b001: begin
            opb = shamt6;
            if (instr[31:26] == 6'b000000) op = ALU_SLL;
            else legal = 1'b0;
          end
          3'b101: begin
            opb = shamt6;
            if (instr[31:26] == 6'b000000)      op = ALU_SRL;
            else if (instr[31:26] == 6'b010000) op = ALU_SRA;
            else legal = 1'b0;
          end
        endcase
      end
      OP_32: begin
        if (funct3 == 3'b000 && funct7 == F7_BASE)      op = ALU_ADDW;
        else if (funct3 == 3'b000 && funct7 == F7_ALT)  op = ALU_SUBW;
        else if (funct3 == 3'b001 && funct7 == F7_BASE) op = ALU_SLLW;
        else if (funct3 == 3'b101 && funct7 == F7_BASE) op = ALU_SRLW;
        else if (funct3 == 3'b101 && funct7 == F7_ALT)  op = ALU_SRAW;
        else legal = 1'b0;
      end
      OP_IMM_32: begin
        opb = imm_i;
        // word shifts take a 5-bit shamt; instr[25] set falls out as illegal
        if (funct3 == 3'b000) begin
          op = ALU_ADDW;
        end else if (funct3 == 3'b001 && funct7 == F7_BASE) begin
          op = ALU_SLLW;
          opb = shamt5;
        end else if (funct3 == 3'b101 && funct7 == F7_BASE) begin
          op = ALU_SRLW;
          opb = shamt5;
        end else if (funct3 == 3'b101 && funct7 == F7_ALT) begin
          op = ALU_SRAW;
          opb = shamt5;
        end else begin
          legal = 1'b0;
        end
      end
      LUI: begin
        opa = '0;
        opb = imm_u;
      end
      AUIPC: begin
        opa = pc;
        opb = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    req         = '0;
    req.rd      = rd;
    req.illegal = !legal;
    if (legal) begin
      req.a    = opa;
      req.b    = opb;
      req.aluc = op;
      req.wen  = (rd != 5'd0);
    end
  end

endmodule

// File: rtl/id_alu_ctrl.sv
// Decode-to-EX pipeline stage: decodes one instruction per handshake into an
// ALU request and holds it in a single-entry valid/ready register.
module id_alu_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_aluc,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal
);

  alu_req_t dec_req;
  alu_req_t req_q;
  alu_req_t req_d;
  logic     valid_q;
  logic     valid_d;
  logic     take;

  alu_ctrl_dec u_dec (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .req   (dec_req)
  );

  assign in_ready = !valid_q || out_ready;
  assign take     = in_valid && in_ready && !flush;

  // flush only kills valid; the data register keeps its last contents
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (take) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (take) begin
      req_d = dec_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = req_q.a;
  assign out_b       = req_q.b;
  assign out_aluc    = req_q.aluc;
  assign out_rd      = req_q.rd;
  assign out_wen     = req_q.wen;
  assign out_illegal = req_q.illegal;

endmodule

// File: tb/tb_id_alu_ctrl.sv
// Directed self-checking bench for id_alu_ctrl: decode vectors, streaming,
// backpressure, flush and reset-during-stall.
module tb_id_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  out_aluc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_alu_ctrl #(.XLEN(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_aluc    (out_aluc),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  // {valid, illegal, wen, aluc, rd, a, b}
  function automatic logic [139:0] pack(input logic v, input logic ill, input logic wen,
                                        input logic [3:0] aluc, input logic [4:0] rd,
                                        input logic [63:0] a, input logic [63:0] b);
    return {v, ill, wen, aluc, rd, a, b};
  endfunction

  function automatic logic [139:0] observed();
    return pack(out_valid, out_illegal, out_wen, out_aluc, out_rd, out_a, out_b);
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] rs1, input logic [63:0] rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    $display("tx instr=%h pc=%h rs1=%h rs2=%h", instr, pc, rs1, rs2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [139:0] exp_v;
    exp_v = pack(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 64'd0, 64'd0);
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (observed() !== exp_v || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got=%h rdy=%b want=%h rdy=1", observed(), in_ready, exp_v);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (observed() !== exp_v || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_reset got=%h rdy=%b want=%h rdy=1", observed(), in_ready, exp_v);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        ill;
    logic        wen;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  // Streams the vectors one per cycle with out_ready high.
  task automatic test_decode();
    vec_t v[11];
    logic [139:0] exp_v;
    v[0]  = '{32'h002081B3, 64'h0,    64'd5,   64'd7, 0, 1, 4'd0,  5'd3,  64'd5, 64'd7};
    v[1]  = '{32'h43F35293, 64'h0,    64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 1, 4'd9, 5'd5,
              64'hFFFF_FFFF_FFFF_FFF8, 64'd63};
    v[2]  = '{32'h4233529B, 64'h0,    64'd1,   64'd2, 1, 0, 4'd0,  5'd5,  64'd0, 64'd0};
    v[3]  = '{32'h80000097, 64'h1000, 64'd9,   64'd9, 0, 1, 4'd0,  5'd1,  64'h1000,
              64'hFFFF_FFFF_8000_0000};
    v[4]  = '{32'h00001037, 64'h2000, 64'd9,   64'd9, 0, 0, 4'd0,  5'd0,  64'd0, 64'h1000};
    v[5]  = '{32'hFFF58513, 64'h0,    64'd100, 64'd3, 0, 1, 4'd0,  5'd10, 64'd100,
              64'hFFFF_FFFF_FFFF_FFFF};
    v[6]  = '{32'h40628233, 64'h0,    64'd3,   64'd2, 0, 1, 4'd1,  5'd4,  64'd3, 64'd2};
    v[7]  = '{32'h01F4139B, 64'h0,    64'd5,   64'd6, 0, 1, 4'd12, 5'd7,  64'd5, 64'd31};
    v[8]  = '{32'h40B504BB, 64'h0,    64'd1,   64'd2, 0, 1, 4'd11, 5'd9,  64'd1, 64'd2};
    v[9]  = '{32'h023100B3, 64'h0,    64'd4,   64'd5, 1, 0, 4'd0,  5'd1,  64'd0, 64'd0};
    v[10] = '{32'h00033283, 64'h0,    64'd4,   64'd5, 1, 0, 4'd0,  5'd5,  64'd0, 64'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      tick();
      exp_v = pack(1'b1, v[i].ill, v[i].wen, v[i].aluc, v[i].rd, v[i].a, v[i].b);
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL decode[%0d] got=%h want=%h", i, observed(), exp_v);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL decode_drain out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [139:0] exp_a;
    logic [139:0] exp_b;
    logic [139:0] exp_c;
    logic [139:0] exp_d;
    exp_a = pack(1'b1, 1'b0, 1'b1, 4'd0,  5'd3, 64'd5,  64'd7);
    exp_b = pack(1'b1, 1'b0, 1'b1, 4'd1,  5'd4, 64'd3,  64'd2);
    exp_c = pack(1'b1, 1'b0, 1'b1, 4'd11, 5'd9, 64'd20, 64'd30);
    exp_d = pack(1'b1, 1'b0, 1'b1, 4'd12, 5'd7, 64'd40, 64'd31);
    out_ready = 1'b0;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    tick();
    drive(32'h40628233, 64'h0, 64'd3, 64'd2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (observed() !== exp_a || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d] got=%h rdy=%b want=%h rdy=0", i, observed(), in_ready, exp_a);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got=%b want=1", in_ready);
    end
    tick();
    checks++;
    if (observed() !== exp_b) begin
      errors++;
      $display("FAIL b2b_first got=%h want=%h", observed(), exp_b);
    end
    drive(32'h40B504BB, 64'h0, 64'd20, 64'd30);
    tick();
    checks++;
    if (observed() !== exp_c) begin
      errors++;
      $display("FAIL b2b_second got=%h want=%h", observed(), exp_c);
    end
    drive(32'h01F4139B, 64'h0, 64'd40, 64'd9);
    tick();
    checks++;
    if (observed() !== exp_d) begin
      errors++;
      $display("FAIL b2b_third got=%h want=%h", observed(), exp_d);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    logic [139:0] exp_held;
    exp_held = pack(1'b0, 1'b0, 1'b1, 4'd0, 5'd3, 64'd5, 64'd7);
    out_ready = 1'b0;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    tick();
    drive(32'h40628233, 64'h0, 64'd3, 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp_held || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_stalled got=%h rdy=%b want=%h rdy=1", observed(), in_ready, exp_held);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_deliver out_valid got=%b want=0", out_valid);
    end
    // flush with an empty register and in_ready high still drops the input
    out_ready = 1'b1;
    drive(32'h40B504BB, 64'h0, 64'd1, 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp_held) begin
      errors++;
      $display("FAIL flush_empty got=%h want=%h", observed(), exp_held);
    end
  endtask

  task automatic test_reset_stall();
    logic [139:0] exp_zero;
    logic [139:0] exp_mul;
    exp_zero = pack(1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 64'd0, 64'd0);
    exp_mul  = pack(1'b1, 1'b1, 1'b0, 4'd0, 5'd1, 64'd0, 64'd0);
    out_ready = 1'b0;
    drive(32'h002081B3, 64'h0, 64'd5, 64'd7);
    tick();
    drive(32'h40628233, 64'h0, 64'd3, 64'd2);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp_zero || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got=%h rdy=%b want=%h rdy=1", observed(), in_ready, exp_zero);
    end
    out_ready = 1'b1;
    drive(32'h023100B3, 64'h0, 64'd4, 64'd5);
    tick();
    in_valid = 1'b0;
    checks++;
    if (observed() !== exp_mul) begin
      errors++;
      $display("FAIL mul_illegal got=%h want=%h", observed(), exp_mul);
    end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    out_ready = 1'b1;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
